bytecode_fetch: RTL and testbench
=================================

// Module: bytecode_fetch
// PURPOSE
//  Bytecode fetch/assembly unit: the producer side of the opcode decoder interface.
//  - Reads the JVM method bytestream one byte per request from synchronous program memory.
//  - Drives each opcode to the decoder and uses the returned argc to fetch 0-2 operand bytes.
//  - Presents the assembled instruction (opcode, operands, pc) to the execute stage over valid/ready.
//  - Redirects the program counter on jump (goto, if*, if_icmp*).
// PARAMETERS
//  ADDR_W    16  program counter / memory address width
//  RESET_PC  0   pc loaded on reset
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  rst_n         in   1       synchronous active-low reset
//  mem_rd        out  1       program memory read strobe
//  mem_addr      out  ADDR_W  program memory byte address (meaningful when mem_rd=1)
//  mem_data      in   8       read data, valid the cycle after mem_rd=1
//  dec_opcode    out  8       opcode to decoder (registered copy of current opcode)
//  dec_argc      in   2       decoder operand byte count for dec_opcode (combinational)
//  instr_valid   out  1       assembled instruction available
//  instr_ready   in   1       execute stage accepts instruction
//  instr_opcode  out  8       opcode
//  instr_args    out  16      operands: argc=0 -> 0; argc=1 -> {8'h00,b1}; argc=2 -> {b1,b2}
//  instr_pc      out  ADDR_W  address of the opcode byte
//  jump          in   1       redirect request
//  jump_target   in   ADDR_W  new pc when jump=1
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc=RESET_PC; state=OPREQ; opcode, args, instr_pc, remaining = 0.
//    - mem_rd=0 and instr_valid=0 while rst_n=0 (combinational outputs gated by rst_n).
//  - FSM, mem_rd/mem_addr decoded from state:
//    - OPREQ:  mem_rd=1, mem_addr=pc; instr_pc<=pc; pc<=pc+1; -> OPCAP.
//    - OPCAP:  opcode<=mem_data; args<=0; -> DECODE.
//    - DECODE: n=dec_argc (3 treated as 2).
//      - n=0: -> VALID.
//      - else: remaining<=n; mem_rd=1, mem_addr=pc; pc<=pc+1; -> ARGCAP.
//    - ARGCAP: args<={args[7:0],mem_data}; remaining<=remaining-1.
//      - remaining==1: -> VALID.
//      - else: mem_rd=1, mem_addr=pc; pc<=pc+1; stay.
//    - VALID:  instr_valid=1; outputs held stable until instr_ready=1, then -> OPREQ.
//  - Latency from OPREQ entry to instr_valid: 3 cycles (argc 0), 4 (argc 1), 5 (argc 2).
//  - Throughput with instr_ready tied high: one instruction per 4+argc cycles.
//  - Jump: sampled in every state, highest priority.
//    - pc<=jump_target; state<=OPREQ; in-flight bytes discarded; no mem_rd that cycle.
//    - jump with instr_valid & instr_ready: the instruction counts as consumed.
//    - jump in VALID without ready: the instruction is dropped.
//  - pc increments wrap modulo 2^ADDR_W; operand fetch continues across the wrap.
//  - Reset mid-fetch: returns to OPREQ at RESET_PC next cycle; no partial instruction is emitted.
//  - Unknown opcodes pass through with the decoder's argc; this block never faults.
// TESTING
//  - mem[0]=03, reset release, ready=1 -> mem_rd@c0 addr 0; valid@c3: opcode 03, args 0000, pc 0.
//  - mem[1..2]=10 05 -> valid: opcode 10, args 0005, pc 1; mem addresses 1,2 read exactly once each.
//  - mem[3..5]=11 01 2c -> opcode 11, args 012c, pc 3; next OPREQ addr 6.
//  - Hold ready=0 for 5 cycles on sipush -> valid and all outputs stable; no mem_rd; accepted on ready=1.
//  - Decode a7 ff fa at 6, then pulse jump with target 0 during ARGCAP.
//    -> next cycle OPREQ addr 0; no valid for the partial goto.
//  - ADDR_W=4, pc=14, mem[14..15,0]=11 aa bb -> args aabb, next OPREQ addr 1.
//  - rst_n=0 for 1 cycle mid-ARGCAP -> instr_valid stays 0; next mem_addr=RESET_PC.

Source files
------------

// File: rtl/bytecode_fetch.sv
// Bytecode fetch/assembly unit: pulls opcode and operand bytes from synchronous
// program memory, sized by the decoder's argc, and presents whole instructions.
module bytecode_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        dec_opcode,
    input  logic [1:0]        dec_argc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [15:0]       instr_args,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target
);

    typedef enum logic [2:0] {
        OPREQ  = 3'd0,
        OPCAP  = 3'd1,
        DECODE = 3'd2,
        ARGCAP = 3'd3,
        VALID  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
    logic [7:0]        opcode_reg, opcode_next;
    logic [15:0]       args_reg, args_next;
    logic [1:0]        remaining_reg, remaining_next;
    logic [1:0]        argc_eff;
    logic              rd_next;

    // The JVM never needs more than two operand bytes here; clamp argc=3.
    assign argc_eff = (dec_argc == 2'd3) ? 2'd2 : dec_argc;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        instr_pc_next  = instr_pc_reg;
        opcode_next    = opcode_reg;
        args_next      = args_reg;
        remaining_next = remaining_reg;
        rd_next        = 1'b0;
        if (jump) begin
            // Redirect wins over everything; in-flight bytes are simply never captured.
            pc_next    = jump_target;
            state_next = OPREQ;
        end else begin
            case (state_reg)
                OPREQ: begin
                    rd_next       = 1'b1;
                    instr_pc_next = pc_reg;
                    pc_next       = pc_reg + ADDR_W'(1);
                    state_next    = OPCAP;
                end
                OPCAP: begin
                    opcode_next = mem_data;
                    args_next   = '0;
                    state_next  = DECODE;
                end
                DECODE: begin
                    if (argc_eff == 2'd0) begin
                        state_next = VALID;
                    end else begin
                        remaining_next = argc_eff;
                        rd_next        = 1'b1;
                        pc_next        = pc_reg + ADDR_W'(1);
                        state_next     = ARGCAP;
                    end
                end
                ARGCAP: begin
                    args_next      = {args_reg[7:0], mem_data};
                    remaining_next = remaining_reg - 2'd1;
                    if (remaining_reg == 2'd1) begin
                        state_next = VALID;
                    end else begin
                        rd_next = 1'b1;
                        pc_next = pc_reg + ADDR_W'(1);
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        state_next = OPREQ;
                    end
                end
                default: state_next = OPREQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= OPREQ;
            pc_reg        <= RESET_PC;
            instr_pc_reg  <= '0;
            opcode_reg    <= '0;
            args_reg      <= '0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            instr_pc_reg  <= instr_pc_next;
            opcode_reg    <= opcode_next;
            args_reg      <= args_next;
            remaining_reg <= remaining_next;
        end
    end

    // Strobes are gated by rst_n so nothing leaks out while reset is held.
    assign mem_rd       = rst_n & rd_next;
    assign mem_addr     = pc_reg;
    assign instr_valid  = rst_n & (state_reg == VALID);
    assign dec_opcode   = opcode_reg;
    assign instr_opcode = opcode_reg;
    assign instr_args   = args_reg;
    assign instr_pc     = instr_pc_reg;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Scoreboard bench for bytecode_fetch: behavioural program memory and decoder,
// expected instructions queued when memory is loaded and popped on acceptance.
module tb_bytecode_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_argc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_args;
    logic [15:0] instr_pc;
    logic        jump;
    logic [15:0] jump_target;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] args;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] rd_log[$];
    logic [7:0]  mem [0:65535];
    int          n_vec = 0;
    int          n_err = 0;

    bytecode_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .dec_opcode(dec_opcode), .dec_argc(dec_argc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_args(instr_args), .instr_pc(instr_pc),
        .jump(jump), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    // Synchronous program memory; every accepted read is logged
    always @(posedge clk) begin
        if (mem_rd === 1'b1) begin
            mem_data <= mem[mem_addr];
            rd_log.push_back(mem_addr);
        end
    end

    // Decoder model: bipush=1, sipush/goto/ifeq=2, 0xff deliberately reports 3
    always_comb begin
        dec_argc = 2'd0;
        case (dec_opcode)
            8'h10:                dec_argc = 2'd1;
            8'h11, 8'ha7, 8'h99:  dec_argc = 2'd2;
            8'hff:                dec_argc = 2'd3;
            default:              dec_argc = 2'd0;
        endcase
    end

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [15:0] args, input logic [15:0] pc);
        exp_t e;
        e.op = op; e.args = args; e.pc = pc;
        sb.push_back(e);
    endtask

    // Leaves the caller 1 time unit after the negedge where rst_n was released
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        jump  = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rd_log.delete();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; jump = 1'b0; jump_target = '0; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || instr_args !== 16'h0 ||
            instr_pc !== 16'h0 || dec_opcode !== 8'h0) begin
            n_err++;
            $display("FAIL reset: got rd=%b valid=%b args=%h pc=%h op=%h, want 0 0 0000 0000 00",
                     mem_rd, instr_valid, instr_args, instr_pc, dec_opcode);
        end
    endtask

    task automatic test_sequence();
        exp_t e;
        bit ok;
        logic [15:0] want_rd[6];
        bit log_ok;
        clear_mem();
        mem[0] = 8'h03;
        mem[1] = 8'h10; mem[2] = 8'h05;
        mem[3] = 8'h11; mem[4] = 8'h01; mem[5] = 8'h2c;
        instr_ready = 1'b1;
        do_reset();
        push_exp(8'h03, 16'h0000, 16'h0000);
        push_exp(8'h10, 16'h0005, 16'h0001);
        push_exp(8'h11, 16'h012c, 16'h0003);
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0) begin
            n_err++;
            $display("FAIL first_fetch: got rd=%b addr=%h, want 1 0000", mem_rd, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_valid: got valid=%b at c2, want 0", instr_valid);
        end
        for (int k = 0; k < 3; k++) begin
            wait_valid((k == 0) ? 1 : 12, ok);
            n_vec++;
            if (!ok || sb.size() == 0) begin
                n_err++;
                $display("FAIL seq_instr%0d: got no valid in budget (ok=%b), want instruction", k, ok);
            end else begin
                e = sb.pop_front();
                if (instr_opcode !== e.op || instr_args !== e.args || instr_pc !== e.pc) begin
                    n_err++;
                    $display("FAIL seq_instr%0d: got op=%h args=%h pc=%h, want op=%h args=%h pc=%h",
                             k, instr_opcode, instr_args, instr_pc, e.op, e.args, e.pc);
                end
            end
        end
        want_rd = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        log_ok = (rd_log.size() == 6);
        if (log_ok) for (int i = 0; i < 6; i++) if (rd_log[i] !== want_rd[i]) log_ok = 1'b0;
        n_vec++;
        if (!log_ok) begin
            n_err++;
            $display("FAIL read_once: got %0d reads %p, want 6 reads 0..5", rd_log.size(), rd_log);
        end
        @(negedge clk);
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0006) begin
            n_err++;
            $display("FAIL next_opreq: got rd=%b addr=%h, want 1 0006", mem_rd, mem_addr);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit ok;
        logic [39:0] snap;
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
        instr_ready = 1'b0;
        do_reset();
        push_exp(8'h11, 16'h1234, 16'h0000);
        wait_valid(10, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL bp_instr: got no valid in budget, want instruction");
        end else begin
            e = sb.pop_front();
            if (instr_opcode !== e.op || instr_args !== e.args || instr_pc !== e.pc) begin
                n_err++;
                $display("FAIL bp_instr: got op=%h args=%h pc=%h, want op=%h args=%h pc=%h",
                         instr_opcode, instr_args, instr_pc, e.op, e.args, e.pc);
            end
        end
        snap = {instr_opcode, instr_args, instr_pc};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (instr_valid !== 1'b1 || mem_rd !== 1'b0 ||
                {instr_opcode, instr_args, instr_pc} !== snap) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid=%b rd=%b outs=%h, want 1 0 %h",
                         c, instr_valid, mem_rd, {instr_opcode, instr_args, instr_pc}, snap);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0003) begin
            n_err++;
            $display("FAIL bp_accept: got valid=%b rd=%b addr=%h, want 0 1 0003",
                     instr_valid, mem_rd, mem_addr);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        bit ok;
        clear_mem();
        mem[6] = 8'ha7; mem[7] = 8'hff; mem[8] = 8'hfa;
        mem[0] = 8'h03;
        instr_ready = 1'b1;
        do_reset();
        jump = 1'b1; jump_target = 16'h0006;
        #1;
        n_vec++;
        if (mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL jump_no_rd: got rd=%b, want 0", mem_rd);
        end
        @(negedge clk);
        jump = 1'b0;
        #1;
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0006) begin
            n_err++;
            $display("FAIL jump_target: got rd=%b addr=%h, want 1 0006", mem_rd, mem_addr);
        end
        repeat (3) @(negedge clk);
        jump = 1'b1; jump_target = 16'h0000;
        #1;
        n_vec++;
        if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_argcap: got rd=%b valid=%b, want 0 0", mem_rd, instr_valid);
        end
        @(negedge clk);
        jump = 1'b0;
        instr_ready = 1'b0;
        #1;
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_redirect: got rd=%b addr=%h valid=%b, want 1 0000 0",
                     mem_rd, mem_addr, instr_valid);
        end
        push_exp(8'h03, 16'h0000, 16'h0000);
        wait_valid(8, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL jump_instr: got no valid in budget, want instruction");
        end else begin
            e = sb.pop_front();
            if (instr_opcode !== e.op || instr_args !== e.args || instr_pc !== e.pc) begin
                n_err++;
                $display("FAIL jump_instr: got op=%h args=%h pc=%h, want op=%h args=%h pc=%h",
                         instr_opcode, instr_args, instr_pc, e.op, e.args, e.pc);
            end
        end
        jump = 1'b1; jump_target = 16'h0010;
        @(negedge clk);
        jump = 1'b0;
        #1;
        n_vec++;
        if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin
            n_err++;
            $display("FAIL jump_drop: got valid=%b rd=%b addr=%h, want 0 1 0010",
                     instr_valid, mem_rd, mem_addr);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit ok;
        clear_mem();
        mem[16'hfffe] = 8'h11; mem[16'hffff] = 8'haa; mem[0] = 8'hbb;
        instr_ready = 1'b1;
        do_reset();
        jump = 1'b1; jump_target = 16'hfffe;
        @(negedge clk);
        jump = 1'b0;
        push_exp(8'h11, 16'haabb, 16'hfffe);
        wait_valid(10, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL wrap_instr: got no valid in budget, want instruction");
        end else begin
            e = sb.pop_front();
            if (instr_opcode !== e.op || instr_args !== e.args || instr_pc !== e.pc) begin
                n_err++;
                $display("FAIL wrap_instr: got op=%h args=%h pc=%h, want op=%h args=%h pc=%h",
                         instr_opcode, instr_args, instr_pc, e.op, e.args, e.pc);
            end
        end
        @(negedge clk);
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin
            n_err++;
            $display("FAIL wrap_next: got rd=%b addr=%h, want 1 0001", mem_rd, mem_addr);
        end
    endtask

    task automatic test_argc3();
        exp_t e;
        bit ok;
        clear_mem();
        mem[0] = 8'hff; mem[1] = 8'h12; mem[2] = 8'h34;
        instr_ready = 1'b1;
        do_reset();
        push_exp(8'hff, 16'h1234, 16'h0000);
        wait_valid(10, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL argc3_instr: got no valid in budget, want instruction");
        end else begin
            e = sb.pop_front();
            if (instr_opcode !== e.op || instr_args !== e.args || instr_pc !== e.pc) begin
                n_err++;
                $display("FAIL argc3_instr: got op=%h args=%h pc=%h, want op=%h args=%h pc=%h",
                         instr_opcode, instr_args, instr_pc, e.op, e.args, e.pc);
            end
        end
        @(negedge clk);
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0003) begin
            n_err++;
            $display("FAIL argc3_next: got rd=%b addr=%h, want 1 0003", mem_rd, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit ok;
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h01; mem[2] = 8'h02;
        instr_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_hold: got rd=%b valid=%b, want 0 0", mem_rd, instr_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0 || instr_args !== 16'h0) begin
            n_err++;
            $display("FAIL rstmid_restart: got rd=%b addr=%h valid=%b args=%h, want 1 0000 0 0000",
                     mem_rd, mem_addr, instr_valid, instr_args);
        end
        push_exp(8'h11, 16'h0102, 16'h0000);
        wait_valid(10, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL rstmid_instr: got no valid in budget, want instruction");
        end else begin
            e = sb.pop_front();
            if (instr_opcode !== e.op || instr_args !== e.args || instr_pc !== e.pc) begin
                n_err++;
                $display("FAIL rstmid_instr: got op=%h args=%h pc=%h, want op=%h args=%h pc=%h",
                         instr_opcode, instr_args, instr_pc, e.op, e.args, e.pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_jump();
        test_wrap();
        test_argc3();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
